// File: rtl/tcb_pkg.sv
// Shared TCB library types and elaboration-time parameter checks.
// TCB_RSP_T builds the per-stage response tag for a given data width.
`ifndef TCB_RSP_T
`define TCB_RSP_T(dat) struct packed { logic act; logic wen; logic [(dat)-1:0] rdt; logic err; }
`endif

package tcb_pkg;

  // Request-tracking tag: a transfer happened, and whether it was a write.
  typedef struct packed {
    logic act;
    logic wen;
  } tcb_trk_t;

  function automatic bit tcb_dly_ok(input int dly_sub, input int dly_man);
    return (dly_man >= 0) && (dly_man <= dly_sub);
  endfunction

  function automatic bit tcb_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/tcb_lib_delay_line.sv
// Generic DEPTH-stage shift register of any packed type; DEPTH=0 is a wire.
// Shifts every cycle with no stall, so latency is exactly DEPTH cycles.
module tcb_lib_delay_line #(
  parameter int  DEPTH = 1,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  T     din,
  output T     dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_shift
    T stg [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
      end else begin
        stg[0] <= din;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end

    assign dout = stg[DEPTH-1];
  end

endmodule

// File: rtl/tcb_lib_delay_adapter.sv
// Retimes subordinate responses (DLY_MAN) to the fixed DLY_SUB the manager expects.
// Requests pass straight through; the response line never stalls.
module tcb_lib_delay_adapter
  import tcb_pkg::*;
#(
  parameter int DLY_SUB = 2,
  parameter int DLY_MAN = 1,
  parameter int UNT     = 8,
  parameter int ADR     = 32,
  parameter int DAT     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sub_vld,
  output logic                         sub_rdy,
  input  logic                         sub_wen,
  input  logic [ADR-1:0]               sub_adr,
  input  logic [DAT/UNT-1:0]           sub_ben,
  input  logic [DAT-1:0]               sub_wdt,
  output logic [DAT-1:0]               sub_rdt,
  output logic                         sub_err,
  output logic                         man_vld,
  input  logic                         man_rdy,
  output logic                         man_wen,
  output logic [ADR-1:0]               man_adr,
  output logic [DAT/UNT-1:0]           man_ben,
  output logic [DAT-1:0]               man_wdt,
  input  logic [DAT-1:0]               man_rdt,
  input  logic                         man_err,
  output logic [$clog2(DLY_SUB+1)-1:0] cnt
);

  localparam int CW = $clog2(DLY_SUB+1);
  localparam int L  = DLY_SUB - DLY_MAN;

  if (!tcb_dly_ok(DLY_SUB, DLY_MAN)) begin : g_bad_dly
    $fatal(1, "tcb_lib_delay_adapter: DLY_MAN must not exceed DLY_SUB");
  end
  if (!tcb_pow2(DAT / UNT) || (DAT % UNT) != 0) begin : g_bad_dat
    $fatal(1, "tcb_lib_delay_adapter: DAT/UNT must be a power of 2");
  end

  typedef `TCB_RSP_T(DAT) rsp_t;

  logic     trn;
  tcb_trk_t trk_in, trk_m;
  rsp_t     rsp_in, rsp_o;

  assign man_vld = sub_vld;
  assign man_wen = sub_wen;
  assign man_adr = sub_adr;
  assign man_ben = sub_ben;
  assign man_wdt = sub_wdt;
  assign sub_rdy = man_rdy;
  assign trn     = sub_vld & man_rdy;

  assign trk_in = '{act: trn, wen: sub_wen};

  tcb_lib_delay_line #(.DEPTH(DLY_MAN), .T(tcb_trk_t)) u_trk (
    .clk  (clk),
    .rst  (rst),
    .din  (trk_in),
    .dout (trk_m)
  );

  // Untagged cycles carry all-zero payload so stale bus data never enters the line.
  always_comb begin
    rsp_in     = '0;
    rsp_in.act = trk_m.act;
    if (trk_m.act) begin
      rsp_in.wen = trk_m.wen;
      rsp_in.rdt = man_rdt;
      rsp_in.err = man_err;
    end
  end

  tcb_lib_delay_line #(.DEPTH(L), .T(rsp_t)) u_rsp (
    .clk  (clk),
    .rst  (rst),
    .din  (rsp_in),
    .dout (rsp_o)
  );

  assign sub_rdt = (rsp_o.act && !rsp_o.wen) ? rsp_o.rdt : '0;
  assign sub_err = rsp_o.act & rsp_o.err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      case ({trn, rsp_o.act})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  a_cnt_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_o.act && !trn && cnt == '0));
  a_cnt_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(trn && !rsp_o.act && cnt == CW'(DLY_SUB)));

endmodule

// File: tb/tb_tcb_lib_delay_adapter.sv
// Directed bench: four adapter instances (2/1, 3/0, 4/1, 1/1) share one request
// stream and subordinate bus; each scenario checks the instance it targets.
module tb_tcb_lib_delay_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sub_vld, sub_wen, man_rdy, man_err;
  logic [31:0] sub_adr, sub_wdt, man_rdt;
  logic [3:0]  sub_ben;

  logic        s_rdy [4];
  logic [31:0] s_rdt [4];
  logic        s_err [4];
  logic        m_vld [4];
  logic        m_wen [4];
  logic [31:0] m_adr [4];
  logic [31:0] m_wdt [4];
  logic [3:0]  m_ben [4];
  logic [1:0]  c21, c30;
  logic [2:0]  c41;
  logic [0:0]  c11;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcb_lib_delay_adapter #(.DLY_SUB(2), .DLY_MAN(1)) u21 (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(s_rdy[0]), .sub_wen(sub_wen),
    .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdt(s_rdt[0]),
    .sub_err(s_err[0]), .man_vld(m_vld[0]), .man_rdy(man_rdy), .man_wen(m_wen[0]),
    .man_adr(m_adr[0]), .man_ben(m_ben[0]), .man_wdt(m_wdt[0]), .man_rdt(man_rdt),
    .man_err(man_err), .cnt(c21));

  tcb_lib_delay_adapter #(.DLY_SUB(3), .DLY_MAN(0)) u30 (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(s_rdy[1]), .sub_wen(sub_wen),
    .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdt(s_rdt[1]),
    .sub_err(s_err[1]), .man_vld(m_vld[1]), .man_rdy(man_rdy), .man_wen(m_wen[1]),
    .man_adr(m_adr[1]), .man_ben(m_ben[1]), .man_wdt(m_wdt[1]), .man_rdt(man_rdt),
    .man_err(man_err), .cnt(c30));

  tcb_lib_delay_adapter #(.DLY_SUB(4), .DLY_MAN(1)) u41 (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(s_rdy[2]), .sub_wen(sub_wen),
    .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdt(s_rdt[2]),
    .sub_err(s_err[2]), .man_vld(m_vld[2]), .man_rdy(man_rdy), .man_wen(m_wen[2]),
    .man_adr(m_adr[2]), .man_ben(m_ben[2]), .man_wdt(m_wdt[2]), .man_rdt(man_rdt),
    .man_err(man_err), .cnt(c41));

  tcb_lib_delay_adapter #(.DLY_SUB(1), .DLY_MAN(1)) u11 (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(s_rdy[3]), .sub_wen(sub_wen),
    .sub_adr(sub_adr), .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rdt(s_rdt[3]),
    .sub_err(s_err[3]), .man_vld(m_vld[3]), .man_rdy(man_rdy), .man_wen(m_wen[3]),
    .man_adr(m_adr[3]), .man_ben(m_ben[3]), .man_wdt(m_wdt[3]), .man_rdt(man_rdt),
    .man_err(man_err), .cnt(c11));

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic r, input logic [31:0] rd,
                       input logic e);
    sub_vld = v; sub_wen = w; sub_adr = a; sub_wdt = d; sub_ben = 4'hF;
    man_rdy = r; man_rdt = rd; man_err = e;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      nxt();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    nxt(); nxt();
    drive(1'b1, 1'b1, 32'h0000_0ABC, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF, 1'b1);
    sub_ben = 4'h5;
    #2;
    checks++; if (c21 !== 2'd0) begin errors++; $display("FAIL rst_cnt21: got %0d expected 0", c21); end
    checks++; if (c41 !== 3'd0) begin errors++; $display("FAIL rst_cnt41: got %0d expected 0", c41); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (s_rdt[i] !== 32'h0 || s_err[i] !== 1'b0) begin
        errors++; $display("FAIL rst_rsp[%0d]: got rdt=%h err=%b expected 0/0", i, s_rdt[i], s_err[i]);
      end
      checks++; if (s_rdy[i] !== 1'b1 || m_vld[i] !== 1'b1 || m_wen[i] !== 1'b1 ||
                    m_adr[i] !== 32'h0000_0ABC || m_wdt[i] !== 32'hCAFE_F00D || m_ben[i] !== 4'h5) begin
        errors++; $display("FAIL rst_passthru[%0d]: got rdy=%b vld=%b wen=%b adr=%h wdt=%h ben=%h expected 1/1/1/00000abc/cafef00d/5",
                           i, s_rdy[i], m_vld[i], m_wen[i], m_adr[i], m_wdt[i], m_ben[i]);
      end
    end
    man_rdy = 1'b0;
    #1;
    checks++; if (s_rdy[0] !== 1'b0) begin errors++; $display("FAIL rst_rdy_follow: got %b expected 0", s_rdy[0]); end
    nxt();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
  endtask

  task automatic test_write_read();
    idle(2);
    nxt(); drive(1'b1, 1'b1, 32'h10, 32'h0123_4567, 1'b1, 32'h0, 1'b0); #2;
    checks++; if (c21 !== 2'd0) begin errors++; $display("FAIL wr_cnt0: got %0d expected 0", c21); end
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h55, 1'b0); #2;
    checks++; if (c21 !== 2'd1) begin errors++; $display("FAIL wr_cnt1: got %0d expected 1", c21); end
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0); #2;
    checks++; if (s_rdt[0] !== 32'h0 || s_err[0] !== 1'b0) begin
      errors++; $display("FAIL wr_rsp: got rdt=%h err=%b expected 0/0", s_rdt[0], s_err[0]);
    end
    // read at r
    nxt(); drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0); #2;
    checks++; if (c21 !== 2'd0) begin errors++; $display("FAIL rd_cnt_r0: got %0d expected 0", c21); end
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0123_4567, 1'b0); #2;
    checks++; if (c21 !== 2'd1 || s_rdt[0] !== 32'h0) begin
      errors++; $display("FAIL rd_r1: got cnt=%0d rdt=%h expected 1/00000000", c21, s_rdt[0]);
    end
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0); #2;
    checks++; if (c21 !== 2'd1 || s_rdt[0] !== 32'h0123_4567 || s_err[0] !== 1'b0) begin
      errors++; $display("FAIL rd_r2: got cnt=%0d rdt=%h err=%b expected 1/01234567/0", c21, s_rdt[0], s_err[0]);
    end
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0); #2;
    checks++; if (c21 !== 2'd0 || s_rdt[0] !== 32'h0) begin
      errors++; $display("FAIL rd_r3: got cnt=%0d rdt=%h expected 0/00000000", c21, s_rdt[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rexp [8];
    logic [1:0]  cexp [8];
    rexp = '{32'h0, 32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
    cexp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    idle(4);
    for (int i = 0; i < 8; i++) begin
      nxt();
      if (i < 4) drive(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1, 32'hA0 + 32'(i), 1'b0);
      else       drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77, 1'b0);
      #2;
      checks++; if (s_rdt[1] !== rexp[i]) begin
        errors++; $display("FAIL b2b_rdt[%0d]: got %h expected %h", i, s_rdt[1], rexp[i]);
      end
      checks++; if (c30 !== cexp[i]) begin
        errors++; $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", i, c30, cexp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic        rdy  [7];
    logic [31:0] adr  [7];
    logic [31:0] mrdt [7];
    logic [31:0] rexp [7];
    logic [1:0]  cexp [7];
    rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    adr  = '{32'h40, 32'h44, 32'h44, 32'h44, 32'h0, 32'h0, 32'h0};
    mrdt = '{32'hEE, 32'hB0, 32'hEE, 32'hEE, 32'hB3, 32'hEE, 32'hEE};
    rexp = '{32'h0, 32'h0, 32'hB0, 32'h0, 32'h0, 32'hB3, 32'h0};
    cexp = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
    idle(4);
    for (int i = 0; i < 7; i++) begin
      nxt();
      drive(i < 4, 1'b0, adr[i], 32'h0, rdy[i], mrdt[i], 1'b0);
      #2;
      checks++; if (s_rdy[0] !== rdy[i] || s_rdt[0] !== rexp[i] || c21 !== cexp[i]) begin
        errors++; $display("FAIL bp[%0d]: got rdy=%b rdt=%h cnt=%0d expected %b/%h/%0d",
                           i, s_rdy[0], s_rdt[0], c21, rdy[i], rexp[i], cexp[i]);
      end
    end
  endtask

  task automatic test_error();
    idle(4);
    nxt(); drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0, 1'b0); #2;
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hC0, 1'b1); #2;
    checks++; if (s_err[0] !== 1'b0) begin errors++; $display("FAIL err_early: got %b expected 0", s_err[0]); end
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hC1, 1'b1); #2;
    checks++; if (s_err[0] !== 1'b1 || s_rdt[0] !== 32'hC0) begin
      errors++; $display("FAIL err_hit: got err=%b rdt=%h expected 1/000000c0", s_err[0], s_rdt[0]);
    end
    nxt(); drive(1'b1, 1'b1, 32'h20, 32'h1234, 1'b1, 32'h0, 1'b0); #2;
    checks++; if (s_err[0] !== 1'b0) begin errors++; $display("FAIL err_single: got %b expected 0", s_err[0]); end
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99, 1'b0); #2;
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99, 1'b0); #2;
    checks++; if (s_rdt[0] !== 32'h0 || s_err[0] !== 1'b0) begin
      errors++; $display("FAIL err_wr_rsp: got rdt=%h err=%b expected 0/0", s_rdt[0], s_err[0]);
    end
  endtask

  task automatic test_comb();
    idle(4);
    nxt(); drive(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h0, 1'b0); #2;
    checks++; if (c11 !== 1'b0) begin errors++; $display("FAIL comb_cnt0: got %0d expected 0", c11); end
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0); #2;
    checks++; if (s_rdt[3] !== 32'h1234_5678 || c11 !== 1'b1) begin
      errors++; $display("FAIL comb_same: got rdt=%h cnt=%0d expected 12345678/1", s_rdt[3], c11);
    end
    man_rdt = 32'h0BAD_F00D; #1;
    checks++; if (s_rdt[3] !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL comb_follow: got %h expected 0badf00d", s_rdt[3]);
    end
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b0); #2;
    checks++; if (s_rdt[3] !== 32'h0 || c11 !== 1'b0) begin
      errors++; $display("FAIL comb_after: got rdt=%h cnt=%0d expected 0/0", s_rdt[3], c11);
    end
  endtask

  task automatic test_reset_mid();
    idle(6);
    nxt(); drive(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'h0, 1'b0); #2;
    checks++; if (c41 !== 3'd0) begin errors++; $display("FAIL rm_cnt0: got %0d expected 0", c41); end
    nxt(); drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hD0, 1'b1); #2;
    checks++; if (c41 !== 3'd1) begin errors++; $display("FAIL rm_cnt1: got %0d expected 1", c41); end
    rst = 1'b0; #1;
    checks++; if (c41 !== 3'd0) begin errors++; $display("FAIL rm_cnt_clr: got %0d expected 0", c41); end
    for (int j = 2; j <= 8; j++) begin
      nxt();
      if (j == 2) rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hD0, 1'b1);
      #2;
      checks++; if (s_rdt[2] !== 32'h0 || s_err[2] !== 1'b0 || c41 !== 3'd0) begin
        errors++; $display("FAIL rm_quiet[t+%0d]: got rdt=%h err=%b cnt=%0d expected 0/0/0",
                           j, s_rdt[2], s_err[2], c41);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_error();
    test_comb();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
